// File: rtl/sysid_reader.sv
// System-ID reader: fetches the ID and build timestamp words over an Avalon-MM
// read port, compares them against the expected values and reports the result.
module sysid_reader #(
  parameter logic [31:0] EXPECTED_ID = 32'd12345678,
  parameter logic [31:0] EXPECTED_TS = 32'd1431969997,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        address,
  output logic        read,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timed_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_ID = 2'd1,
    ST_RD_TS = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  state_t      state_r;
  state_t      state_s;
  logic [15:0] stall_cnt_r;
  logic [15:0] stall_inc_s;
  logic        stall_hit_s;
  logic        read_s;
  logic        address_s;
  logic        busy_s;
  logic        done_s;
  logic [31:0] id_value_r;
  logic [31:0] ts_value_r;
  logic        id_ok_r;
  logic        ts_ok_r;
  logic        timed_out_r;

  // The stalled cycle that brings the counter up to TIMEOUT is the last one.
  assign stall_inc_s = stall_cnt_r + 16'd1;
  assign stall_hit_s = (stall_inc_s == TIMEOUT_C);

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_RD_ID;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RD_ID: begin
        if (!waitrequest) begin
          state_s = ST_RD_TS;
        end else if (stall_hit_s) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_RD_ID;
        end
      end
      ST_RD_TS: begin
        if (!waitrequest || stall_hit_s) begin
          state_s = ST_FIN;
        end else begin
          state_s = ST_RD_TS;
        end
      end
      ST_FIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode straight from the state register, so reset drops read at once
  always_comb begin
    read_s    = 1'b0;
    address_s = 1'b0;
    busy_s    = 1'b0;
    done_s    = 1'b0;
    case (state_r)
      ST_RD_ID: begin
        read_s = 1'b1;
        busy_s = 1'b1;
      end
      ST_RD_TS: begin
        read_s    = 1'b1;
        address_s = 1'b1;
        busy_s    = 1'b1;
      end
      ST_FIN: begin
        done_s = 1'b1;
      end
      default: begin
        read_s = 1'b0;
      end
    endcase
  end

  // Capture registers and per-word stall counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_r <= 16'd0;
      id_value_r  <= 32'd0;
      ts_value_r  <= 32'd0;
      id_ok_r     <= 1'b0;
      ts_ok_r     <= 1'b0;
      timed_out_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            stall_cnt_r <= 16'd0;
            id_ok_r     <= 1'b0;
            ts_ok_r     <= 1'b0;
            timed_out_r <= 1'b0;
          end
        end
        ST_RD_ID: begin
          if (!waitrequest) begin
            id_value_r  <= readdata;
            id_ok_r     <= (readdata == EXPECTED_ID);
            stall_cnt_r <= 16'd0;
          end else begin
            stall_cnt_r <= stall_inc_s;
            if (stall_hit_s) begin
              timed_out_r <= 1'b1;
            end
          end
        end
        ST_RD_TS: begin
          if (!waitrequest) begin
            ts_value_r <= readdata;
            ts_ok_r    <= (readdata == EXPECTED_TS);
          end else begin
            stall_cnt_r <= stall_inc_s;
            if (stall_hit_s) begin
              timed_out_r <= 1'b1;
            end
          end
        end
        default: begin
          stall_cnt_r <= stall_cnt_r;
        end
      endcase
    end
  end

  assign read      = read_s;
  assign address   = address_s;
  assign busy      = busy_s;
  assign done      = done_s;
  assign id_value  = id_value_r;
  assign ts_value  = ts_value_r;
  assign id_ok     = id_ok_r;
  assign ts_ok     = ts_ok_r;
  assign timed_out = timed_out_r;

endmodule

// File: tb/tb_sysid_reader.sv
// Randomized bench for sysid_reader: a stalling slave model, a transaction-level
// reference model feeding a scoreboard queue, and a monitor popping on done.
module tb_sysid_reader;

  localparam logic [31:0] EXP_ID = 32'd12345678;
  localparam logic [31:0] EXP_TS = 32'd1431969997;
  localparam int          TO     = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        busy;
  logic        done;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic        id_ok;
  logic        ts_ok;
  logic        timed_out;

  sysid_reader #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS),
    .TIMEOUT    (TO)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .address    (address),
    .read       (read),
    .waitrequest(waitrequest),
    .readdata   (readdata),
    .busy       (busy),
    .done       (done),
    .id_value   (id_value),
    .ts_value   (ts_value),
    .id_ok      (id_ok),
    .ts_ok      (ts_ok),
    .timed_out  (timed_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] idv;
    logic [31:0] tsv;
    logic        id_ok;
    logic        ts_ok;
    logic        to;
    int          a0;
    int          a1;
    int          done_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = 0;

  // reference-model state persisting between transactions
  logic [31:0] m_id    = 32'd0;
  logic [31:0] m_ts    = 32'd0;
  logic        m_idok  = 1'b0;
  logic        m_tsok  = 1'b0;
  logic        m_to    = 1'b0;

  // slave configuration for the current transaction
  int          cfg_s0, cfg_s1, w0, w1;
  logic [31:0] cfg_d0, cfg_d1;
  int          rd0, rd1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(posedge clock) cyc <= cyc + 1;

  // slave: stall cfg_sN cycles on word N, then return cfg_dN
  always @(negedge clock) begin
    if (read && !address) begin
      if (w0 < cfg_s0) begin
        waitrequest = 1'b1; readdata = $urandom; w0++;
      end else begin
        waitrequest = 1'b0; readdata = cfg_d0;
      end
    end else if (read && address) begin
      if (w1 < cfg_s1) begin
        waitrequest = 1'b1; readdata = $urandom; w1++;
      end else begin
        waitrequest = 1'b0; readdata = cfg_d1;
      end
    end else begin
      waitrequest = 1'($urandom_range(0, 1));
      readdata    = $urandom;
    end
  end

  // monitor: per-cycle bus sanity plus scoreboard pop on done
  always @(negedge clock) begin
    if (!reset_n) begin
      rd0 = 0;
      rd1 = 0;
    end else begin
      check("busy_vs_read", {31'd0, busy}, {31'd0, read});
      if (!read) check("addr_idle", {31'd0, address}, 32'd0);
      if (read && !address) rd0++;
      if (read && address)  rd1++;
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", {31'd0, done}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("id_value",  id_value,  e.idv);
          check("ts_value",  ts_value,  e.tsv);
          check("id_ok",     {31'd0, id_ok},     {31'd0, e.id_ok});
          check("ts_ok",     {31'd0, ts_ok},     {31'd0, e.ts_ok});
          check("timed_out", {31'd0, timed_out}, {31'd0, e.to});
          check("reads_id",  32'(rd0), 32'(e.a0));
          check("reads_ts",  32'(rd1), 32'(e.a1));
          check("done_cyc",  32'(cyc), 32'(e.done_cyc));
        end
        rd0 = 0;
        rd1 = 0;
      end
    end
  end

  task automatic wait_idle();
    int i;
    i = 0;
    while ((busy || done) && i < 300) begin
      @(negedge clock);
      i++;
    end
    if (busy || done) check("idle_wait_busy", {31'd0, busy | done}, 32'd0);
  endtask

  task automatic run_txn(input int s0, input int s1, input logic [31:0] d0,
                         input logic [31:0] d1, input bit extra, input bit fin_start);
    exp_t e;
    int   i;
    wait_idle();
    check("hold_id",    id_value, m_id);
    check("hold_ts",    ts_value, m_ts);
    check("hold_idok",  {31'd0, id_ok},     {31'd0, m_idok});
    check("hold_tsok",  {31'd0, ts_ok},     {31'd0, m_tsok});
    check("hold_to",    {31'd0, timed_out}, {31'd0, m_to});
    e.to = 1'b0; e.a1 = 0; e.id_ok = 1'b0; e.ts_ok = 1'b0;
    if (s0 >= TO) begin
      e.a0 = TO; e.to = 1'b1;
    end else begin
      e.a0 = s0 + 1; m_id = d0; e.id_ok = (d0 == EXP_ID);
      if (s1 >= TO) begin
        e.a1 = TO; e.to = 1'b1;
      end else begin
        e.a1 = s1 + 1; m_ts = d1; e.ts_ok = (d1 == EXP_TS);
      end
    end
    e.idv = m_id; e.tsv = m_ts;
    e.done_cyc = cyc + e.a0 + e.a1 + 1;
    m_idok = e.id_ok; m_tsok = e.ts_ok; m_to = e.to;
    cfg_s0 = s0; cfg_s1 = s1; cfg_d0 = d0; cfg_d1 = d1; w0 = 0; w1 = 0;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (extra) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    if (fin_start) begin
      i = 0;
      while (!done && i < 300) begin
        @(negedge clock);
        i++;
      end
      if (!done) check("fin_wait_done", {31'd0, done}, 32'd1);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_read"},  {31'd0, read},      32'd0);
    check({tag, "_addr"},  {31'd0, address},   32'd0);
    check({tag, "_busy"},  {31'd0, busy},      32'd0);
    check({tag, "_done"},  {31'd0, done},      32'd0);
    check({tag, "_idok"},  {31'd0, id_ok},     32'd0);
    check({tag, "_tsok"},  {31'd0, ts_ok},     32'd0);
    check({tag, "_to"},    {31'd0, timed_out}, 32'd0);
    check({tag, "_idv"},   id_value,           32'd0);
    check({tag, "_tsv"},   ts_value,           32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          i;
    int          s0, s1;
    logic [31:0] d0, d1;
    reset_n = 1'b0; start = 1'b0; waitrequest = 1'b0; readdata = 32'd0;
    cfg_s0 = 0; cfg_s1 = 0; w0 = 0; w1 = 0; cfg_d0 = 32'd0; cfg_d1 = 32'd0;
    repeat (3) @(negedge clock);
    check_reset_state("rst");
    reset_n = 1'b1;
    @(negedge clock);

    // directed: zero wait, bad ID, 3-cycle stalls, timeouts and boundaries
    run_txn(0, 0, EXP_ID, EXP_TS, 1'b0, 1'b0);
    run_txn(0, 0, 32'hDEADBEEF, EXP_TS, 1'b0, 1'b0);
    run_txn(3, 3, EXP_ID, EXP_TS, 1'b0, 1'b0);
    run_txn(1000, 1000, EXP_ID, EXP_TS, 1'b0, 1'b0);
    run_txn(3, 4, EXP_ID, 32'h0BADF00D, 1'b0, 1'b0);
    run_txn(0, 3, 32'h12345679, EXP_TS, 1'b1, 1'b1);
    run_txn(0, 0, EXP_ID, EXP_TS, 1'b0, 1'b0);

    // extra start while busy, then reset in the timestamp read
    run_txn(1, 50, EXP_ID, EXP_TS, 1'b1, 1'b0);
    i = 0;
    while (!(read && address) && i < 100) begin
      @(negedge clock);
      i++;
    end
    check("reach_rd_ts", {31'd0, read & address}, 32'd1);
    #1 reset_n = 1'b0;
    #1 check_reset_state("midrst");
    exp_q.delete();
    m_id = 32'd0; m_ts = 32'd0; m_idok = 1'b0; m_tsok = 1'b0; m_to = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_state("midrst_hold");
    reset_n = 1'b1;
    @(negedge clock);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      s0 = ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(0, TO));
      s1 = ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(0, TO));
      d0 = ($urandom_range(0, 1) == 1) ? EXP_ID : 32'($urandom);
      d1 = ($urandom_range(0, 1) == 1) ? EXP_TS : 32'($urandom);
      run_txn(s0, s1, d0, d1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    wait_idle();
    repeat (5) @(negedge clock);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
